julia_iter_ctrl: RTL and testbench
==================================

Name: julia_iter_ctrl

Overview:
- Per-pixel iteration controller that sits directly around the Julia single-step calculator.
- Accepts one pixel coordinate and the constant c, then repeatedly drives the step calculator, feeding each z back in, until |z|^2 exceeds the escape limit or MAX_ITER is reached.
- Emits the iteration count through a valid/ready handshake to the downstream colour/pixel-write stage.

Parameters:
- MAX_ITER, 255, maximum iterations per pixel (1..2^ITER_W-1).
- ITER_W, 8, width of the iteration count.
- ESC_LIMIT, 32'sd4000000, escape threshold on |z|^2 (4*SCALE^2 for fixed-point SCALE=1000).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel request valid.
- pix_ready  out  1  controller can accept a pixel.
- pix_x  in  32  signed fixed-point initial x.
- pix_y  in  32  signed fixed-point initial y.
- cr  in  32  signed constant real part, sampled with the pixel.
- ci  in  32  signed constant imaginary part, sampled with the pixel.
- calc_enable  out  1  enable to the step calculator.
- calc_x  out  32  signed current x to the calculator.
- calc_y  out  32  signed current y to the calculator.
- calc_cr  out  32  latched cr.
- calc_ci  out  32  latched ci.
- calc_end  in  1  calculator step-complete flag.
- calc_wx  in  32  signed next x from the calculator.
- calc_wy  in  32  signed next y from the calculator.
- calc_res  in  32  signed |z_next|^2 from the calculator.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_iter  out  ITER_W  iteration count.
- res_escaped  out  1  1 = escaped, 0 = hit MAX_ITER.

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n.
- Reset values: state IDLE; pix_ready=1; calc_enable=0; calc_x/y/cr/ci=0; res_valid=0; res_iter=0; res_escaped=0; internal iteration counter=0.
- Asserting rst_n low mid-operation aborts the pixel immediately. No result is produced for that pixel; calc_enable falls asynchronously.
- All outputs are registered.
- State machine:
  - IDLE: pix_ready=1. On pix_valid&pix_ready, latch pix_x/pix_y into calc_x/calc_y, latch cr/ci, clear the counter, then go to RUN. pix_ready drops the next cycle.
  - RUN: calc_enable=1; wait for calc_end=1. On calc_end, capture calc_wx/calc_wy/calc_res, increment the counter, then go to CHECK.
  - CHECK (1 cycle): calc_enable=0. Escaped if calc_res > ESC_LIMIT (signed compare) or calc_res < 0; a negative value is treated as multiplier overflow and therefore as escape.
    - If escaped: go to DONE with res_escaped=1.
    - Else if counter == MAX_ITER: go to DONE with res_escaped=0.
    - Else: calc_x<=wx, calc_y<=wy, then go to CLR.
  - CLR: calc_enable=0; wait for calc_end=0 so the calculator's start latch clears, then go to RUN.
  - DONE: res_valid=1; res_iter=counter; res_escaped per CHECK. Hold all result outputs stable until res_ready=1. On that cycle go to IDLE, with res_valid=0 and pix_ready=1 the next cycle.
- Iteration count is 1-based: escape detected on the k-th step reports k. A non-escaping pixel reports MAX_ITER with res_escaped=0.
- Escape and MAX_ITER on the same step report escaped=1.
- The counter never wraps, because MAX_ITER ≤ 2^ITER_W-1.
- Each iteration takes at least 4 cycles (RUN ≥2, CHECK 1, CLR ≥1).
- pix_valid while busy is ignored; the upstream source holds its data until accepted.
- pix_valid and res_ready changing in the same cycle have no interaction, because only one pixel is in flight.

Optional Feature:
- Macro JULIA_CYCLE_CNT_EN.
- Defined: adds output res_cycles [31:0], the number of clk cycles from the accept cycle (exclusive) to the cycle res_valid first rises (inclusive).
  - Saturates at 32'hFFFFFFFF.
  - Reset value 0; updated on entry to DONE and held stable with the other result outputs.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- pix=(0,0), c=(0,0), defaults -> res_iter=255, res_escaped=0; calc_enable toggles exactly 255 rising edges.
- pix=(3000,0), c=(0,0) -> first calc_res=81000000 -> res_iter=1, res_escaped=1.
- pix=(1100,0), c=(0,0) -> calc_res sequence 1464100, 2143296, 4592449 -> res_iter=3, res_escaped=1; calc_x sequence 1100, 1210, 1464.
- Hold res_ready=0 for 10 cycles after res_valid -> res_iter/res_escaped stable, pix_ready=0, and a pix_valid pulse is ignored; release -> IDLE next cycle.
- Drop rst_n for one cycle during RUN of the (0,0) case -> calc_enable=0 and res_valid=0 immediately, pix_ready=1 after release; a following pix=(3000,0) gives res_iter=1.
- MAX_ITER=3 with pix=(1100,0) -> res_iter=3, res_escaped=1 (escape wins); pix=(0,0) -> res_iter=3, res_escaped=0.

Source files
------------

// File: rtl/julia_iter_ctrl_if.sv
// ---------------------------------------------------------------------------
// julia_iter_ctrl_if
// Bundles the three links of the Julia iteration controller:
//   pixel request  : pix_valid/pix_ready, pix_x, pix_y, cr, ci
//   step calculator: calc_enable, calc_x/y/cr/ci out; calc_end, calc_wx/wy/res in
//   result         : res_valid/res_ready, res_iter, res_escaped
//                    (+ res_cycles when JULIA_CYCLE_CNT_EN is defined)
// Modports: slave  = the controller itself
//           master = the surrounding environment (source, calculator, sink)
// ---------------------------------------------------------------------------
interface julia_iter_ctrl_if #(
    parameter int ITER_W = 8
);
    logic                     pix_valid;
    logic                     pix_ready;
    logic signed [31:0]       pix_x;
    logic signed [31:0]       pix_y;
    logic signed [31:0]       cr;
    logic signed [31:0]       ci;

    logic                     calc_enable;
    logic signed [31:0]       calc_x;
    logic signed [31:0]       calc_y;
    logic signed [31:0]       calc_cr;
    logic signed [31:0]       calc_ci;
    logic                     calc_end;
    logic signed [31:0]       calc_wx;
    logic signed [31:0]       calc_wy;
    logic signed [31:0]       calc_res;

    logic                     res_valid;
    logic                     res_ready;
    logic [ITER_W-1:0]        res_iter;
    logic                     res_escaped;
`ifdef JULIA_CYCLE_CNT_EN
    logic [31:0]              res_cycles;
`endif

    modport slave (
        input  pix_valid, pix_x, pix_y, cr, ci,
        input  calc_end, calc_wx, calc_wy, calc_res,
        input  res_ready,
        output pix_ready,
        output calc_enable, calc_x, calc_y, calc_cr, calc_ci,
`ifdef JULIA_CYCLE_CNT_EN
        output res_cycles,
`endif
        output res_valid, res_iter, res_escaped
    );

    modport master (
        output pix_valid, pix_x, pix_y, cr, ci,
        output calc_end, calc_wx, calc_wy, calc_res,
        output res_ready,
        input  pix_ready,
        input  calc_enable, calc_x, calc_y, calc_cr, calc_ci,
`ifdef JULIA_CYCLE_CNT_EN
        input  res_cycles,
`endif
        input  res_valid, res_iter, res_escaped
    );
endinterface

// File: rtl/julia_iter_ctrl.sv
// ---------------------------------------------------------------------------
// julia_iter_ctrl
// Per-pixel iteration controller wrapped around the Julia single-step
// calculator. Accepts a pixel and constant c, iterates z <- f(z) through the
// calculator until |z|^2 escapes or MAX_ITER steps are done, then hands the
// 1-based iteration count downstream over a valid/ready handshake.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset (aborts any pixel in flight)
//   bus    - julia_iter_ctrl_if.slave (pixel request, calculator, result)
// Optional: define JULIA_CYCLE_CNT_EN to add bus.res_cycles, the number of
//   cycles from the accept cycle (exclusive) to the first res_valid cycle
//   (inclusive), saturating at 32'hFFFFFFFF.
// ---------------------------------------------------------------------------
module julia_iter_ctrl #(
    parameter int                 MAX_ITER  = 255,
    parameter int                 ITER_W    = 8,
    parameter logic signed [31:0] ESC_LIMIT = 32'sd4000000
) (
    input  logic              clk,
    input  logic              rst_n,
    julia_iter_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_CLR,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [ITER_W-1:0]  r_cnt;
    logic signed [31:0] r_wx;
    logic signed [31:0] r_wy;
    logic signed [31:0] r_res;

    logic               r_pix_ready;
    logic               r_calc_en;
    logic signed [31:0] r_calc_x;
    logic signed [31:0] r_calc_y;
    logic signed [31:0] r_calc_cr;
    logic signed [31:0] r_calc_ci;
    logic               r_res_valid;
    logic [ITER_W-1:0]  r_res_iter;
    logic               r_res_esc;

    // A negative |z|^2 can only come from multiplier overflow, so it counts
    // as escape just like exceeding the limit.
    logic w_escaped;
    assign w_escaped = (r_res > ESC_LIMIT) || (r_res < 32'sd0);

`ifdef JULIA_CYCLE_CNT_EN
    logic [31:0] r_cyc;
    logic [31:0] r_res_cycles;
    logic [31:0] w_cyc_inc;
    assign w_cyc_inc = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;
    assign bus.res_cycles = r_res_cycles;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wx        <= '0;
            r_wy        <= '0;
            r_res       <= '0;
            r_pix_ready <= 1'b1;
            r_calc_en   <= 1'b0;
            r_calc_x    <= '0;
            r_calc_y    <= '0;
            r_calc_cr   <= '0;
            r_calc_ci   <= '0;
            r_res_valid <= 1'b0;
            r_res_iter  <= '0;
            r_res_esc   <= 1'b0;
`ifdef JULIA_CYCLE_CNT_EN
            r_cyc        <= '0;
            r_res_cycles <= '0;
`endif
        end else begin
`ifdef JULIA_CYCLE_CNT_EN
            // r_cyc holds the index of the current cycle counted from accept
            if (r_state == S_RUN || r_state == S_CHECK || r_state == S_CLR)
                r_cyc <= w_cyc_inc;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (bus.pix_valid && r_pix_ready) begin
                        r_calc_x    <= bus.pix_x;
                        r_calc_y    <= bus.pix_y;
                        r_calc_cr   <= bus.cr;
                        r_calc_ci   <= bus.ci;
                        r_cnt       <= '0;
                        r_pix_ready <= 1'b0;
                        r_calc_en   <= 1'b1;
                        r_state     <= S_RUN;
`ifdef JULIA_CYCLE_CNT_EN
                        r_cyc       <= 32'd1;
`endif
                    end
                end
                S_RUN: begin
                    if (bus.calc_end) begin
                        r_wx      <= bus.calc_wx;
                        r_wy      <= bus.calc_wy;
                        r_res     <= bus.calc_res;
                        r_cnt     <= r_cnt + 1'b1;
                        r_calc_en <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_escaped || r_cnt == ITER_W'(MAX_ITER)) begin
                        // escape takes priority when both happen on one step
                        r_res_valid <= 1'b1;
                        r_res_iter  <= r_cnt;
                        r_res_esc   <= w_escaped;
                        r_state     <= S_DONE;
`ifdef JULIA_CYCLE_CNT_EN
                        r_res_cycles <= w_cyc_inc;
`endif
                    end else begin
                        r_calc_x <= r_wx;
                        r_calc_y <= r_wy;
                        r_state  <= S_CLR;
                    end
                end
                S_CLR: begin
                    // let the calculator's start latch drop before re-enabling
                    if (!bus.calc_end) begin
                        r_calc_en <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_pix_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pix_ready   = r_pix_ready;
    assign bus.calc_enable = r_calc_en;
    assign bus.calc_x      = r_calc_x;
    assign bus.calc_y      = r_calc_y;
    assign bus.calc_cr     = r_calc_cr;
    assign bus.calc_ci     = r_calc_ci;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_iter    = r_res_iter;
    assign bus.res_escaped = r_res_esc;

endmodule

// File: tb/tb_julia_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_julia_iter_ctrl
// Directed bench: dut0 uses default parameters, dut1 uses MAX_ITER=3. Each
// DUT drives its own behavioural single-step calculator (SCALE=1000).
// ---------------------------------------------------------------------------
module tb_julia_iter_ctrl;

    logic clk;
    logic rst_n;

    int errs   = 0;
    int checks = 0;

    julia_iter_ctrl_if #(.ITER_W(8)) bus0 ();
    julia_iter_ctrl_if #(.ITER_W(8)) bus1 ();

    julia_iter_ctrl dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    julia_iter_ctrl #(.MAX_ITER(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // behavioural Julia step: z^2 + c with fixed-point scale 1000
    function automatic logic signed [31:0] fx(longint x, longint y, longint c);
        return 32'((x * x - y * y) / 1000 + c);
    endfunction
    function automatic logic signed [31:0] fy(longint x, longint y, longint c);
        return 32'((2 * x * y) / 1000 + c);
    endfunction
    function automatic logic signed [31:0] mag(longint x, longint y);
        return 32'(x * x + y * y);
    endfunction

    // calculator models: end rises one cycle after enable, falls once enable drops
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus0.calc_end <= 1'b0;
        end else if (!bus0.calc_enable) begin
            bus0.calc_end <= 1'b0;
        end else if (!bus0.calc_end) begin
            bus0.calc_end <= 1'b1;
            bus0.calc_wx  <= fx(bus0.calc_x, bus0.calc_y, bus0.calc_cr);
            bus0.calc_wy  <= fy(bus0.calc_x, bus0.calc_y, bus0.calc_ci);
            bus0.calc_res <= mag(fx(bus0.calc_x, bus0.calc_y, bus0.calc_cr),
                                 fy(bus0.calc_x, bus0.calc_y, bus0.calc_ci));
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus1.calc_end <= 1'b0;
        end else if (!bus1.calc_enable) begin
            bus1.calc_end <= 1'b0;
        end else if (!bus1.calc_end) begin
            bus1.calc_end <= 1'b1;
            bus1.calc_wx  <= fx(bus1.calc_x, bus1.calc_y, bus1.calc_cr);
            bus1.calc_wy  <= fy(bus1.calc_x, bus1.calc_y, bus1.calc_ci);
            bus1.calc_res <= mag(fx(bus1.calc_x, bus1.calc_y, bus1.calc_cr),
                                 fy(bus1.calc_x, bus1.calc_y, bus1.calc_ci));
        end
    end

    // enable rising-edge monitor for dut0: count and record calc_x per step
    int     en_rise0 = 0;
    logic   prev_en0;
    longint xq0[$];
    always @(posedge clk) begin
        prev_en0 <= bus0.calc_enable;
        if (bus0.calc_enable && !prev_en0) begin
            en_rise0 <= en_rise0 + 1;
            xq0.push_back(longint'(bus0.calc_x));
        end
    end

    task automatic send(input int sel, input int x, input int y, input int c_r, input int c_i);
        if (sel == 0) begin
            chk("pix_ready0_before_send", longint'(bus0.pix_ready), 1);
            bus0.pix_x = x; bus0.pix_y = y; bus0.cr = c_r; bus0.ci = c_i;
            bus0.pix_valid = 1'b1;
            @(negedge clk);
            bus0.pix_valid = 1'b0;
        end else begin
            chk("pix_ready1_before_send", longint'(bus1.pix_ready), 1);
            bus1.pix_x = x; bus1.pix_y = y; bus1.cr = c_r; bus1.ci = c_i;
            bus1.pix_valid = 1'b1;
            @(negedge clk);
            bus1.pix_valid = 1'b0;
        end
    endtask

    task automatic wait_res(input int sel, input int budget);
        int  n = 0;
        bit  rv;
        rv = (sel == 0) ? bus0.res_valid : bus1.res_valid;
        while (!rv && n < budget) begin
            @(negedge clk);
            n++;
            rv = (sel == 0) ? bus0.res_valid : bus1.res_valid;
        end
        chk("res_valid_timeout", longint'(rv), 1);
    endtask

    task automatic ack(input int sel);
        if (sel == 0) bus0.res_ready = 1'b1; else bus1.res_ready = 1'b1;
        @(negedge clk);
        bus0.res_ready = 1'b0;
        bus1.res_ready = 1'b0;
        if (sel == 0) begin
            chk("ack0_res_valid_low", longint'(bus0.res_valid), 0);
            chk("ack0_pix_ready_high", longint'(bus0.pix_ready), 1);
        end else begin
            chk("ack1_res_valid_low", longint'(bus1.res_valid), 0);
            chk("ack1_pix_ready_high", longint'(bus1.pix_ready), 1);
        end
    endtask

    initial begin
        int     r0;
        int     qs;
        int     n;
        bus0.pix_valid = 0; bus0.pix_x = 0; bus0.pix_y = 0; bus0.cr = 0; bus0.ci = 0;
        bus0.res_ready = 0;
        bus1.pix_valid = 0; bus1.pix_x = 0; bus1.pix_y = 0; bus1.cr = 0; bus1.ci = 0;
        bus1.res_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pix_ready", longint'(bus0.pix_ready), 1);
        chk("rst_calc_enable", longint'(bus0.calc_enable), 0);
        chk("rst_res_valid", longint'(bus0.res_valid), 0);
        chk("rst_res_iter", longint'(bus0.res_iter), 0);
        chk("rst_calc_x", longint'(bus0.calc_x), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // (0,0) never escapes: full 255 steps
        r0 = en_rise0;
        send(0, 0, 0, 0, 0);
        chk("busy_pix_ready_low", longint'(bus0.pix_ready), 0);
        wait_res(0, 2000);
        chk("zero_iter", longint'(bus0.res_iter), 255);
        chk("zero_escaped", longint'(bus0.res_escaped), 0);
        chk("zero_enable_rises", longint'(en_rise0 - r0), 255);
`ifdef JULIA_CYCLE_CNT_EN
        chk("zero_cycles", longint'(bus0.res_cycles), 1020);
`endif
        ack(0);

        // (3000,0): |z1|^2 = 81000000 escapes on step 1
        send(0, 3000, 0, 0, 0);
        wait_res(0, 100);
        chk("p3000_iter", longint'(bus0.res_iter), 1);
        chk("p3000_escaped", longint'(bus0.res_escaped), 1);
`ifdef JULIA_CYCLE_CNT_EN
        chk("p3000_cycles", longint'(bus0.res_cycles), 4);
`endif
        // hold the result 10 cycles; a pix_valid pulse meanwhile is ignored
        r0 = en_rise0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus0.pix_x = 0; bus0.pix_valid = 1'b1;
            end else begin
                bus0.pix_valid = 1'b0;
            end
            @(negedge clk);
            chk("hold_res_valid", longint'(bus0.res_valid), 1);
            chk("hold_res_iter", longint'(bus0.res_iter), 1);
            chk("hold_res_escaped", longint'(bus0.res_escaped), 1);
            chk("hold_pix_ready", longint'(bus0.pix_ready), 0);
        end
        bus0.pix_valid = 1'b0;
        ack(0);
        @(negedge clk);
        chk("ignored_pix_no_enable", longint'(en_rise0 - r0), 0);
        chk("ignored_pix_idle", longint'(bus0.pix_ready), 1);

        // (1100,0): escapes on step 3, calc_x 1100,1210,1464
        r0 = en_rise0;
        qs = xq0.size();
        send(0, 1100, 0, 0, 0);
        wait_res(0, 200);
        chk("p1100_iter", longint'(bus0.res_iter), 3);
        chk("p1100_escaped", longint'(bus0.res_escaped), 1);
        chk("p1100_enable_rises", longint'(en_rise0 - r0), 3);
        if (xq0.size() >= qs + 3) begin
            chk("p1100_x0", xq0[qs], 1100);
            chk("p1100_x1", xq0[qs+1], 1210);
            chk("p1100_x2", xq0[qs+2], 1464);
        end else begin
            chk("p1100_xq_size", longint'(xq0.size() - qs), 3);
        end
`ifdef JULIA_CYCLE_CNT_EN
        chk("p1100_cycles", longint'(bus0.res_cycles), 12);
`endif
        ack(0);

        // reset during RUN aborts the pixel
        send(0, 0, 0, 0, 0);
        n = 0;
        while (!bus0.calc_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_enable_seen", longint'(bus0.calc_enable), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_enable_async", longint'(bus0.calc_enable), 0);
        chk("rst_mid_res_valid", longint'(bus0.res_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_pix_ready", longint'(bus0.pix_ready), 1);
        chk("rst_mid_res_valid_after", longint'(bus0.res_valid), 0);
        send(0, 3000, 0, 0, 0);
        wait_res(0, 100);
        chk("after_rst_iter", longint'(bus0.res_iter), 1);
        chk("after_rst_escaped", longint'(bus0.res_escaped), 1);
        ack(0);

        // MAX_ITER=3: escape on the last step wins
        send(1, 1100, 0, 0, 0);
        wait_res(1, 200);
        chk("m3_p1100_iter", longint'(bus1.res_iter), 3);
        chk("m3_p1100_escaped", longint'(bus1.res_escaped), 1);
        ack(1);

        send(1, 0, 0, 0, 0);
        wait_res(1, 200);
        chk("m3_zero_iter", longint'(bus1.res_iter), 3);
        chk("m3_zero_escaped", longint'(bus1.res_escaped), 0);
        ack(1);

        // c=(500,0): |z|^2 = 250000, 562500, 1127844 -> no escape in 3 steps
        send(1, 0, 0, 500, 0);
        chk("m3_c_latched", longint'(bus1.calc_cr), 500);
        wait_res(1, 200);
        chk("m3_c500_iter", longint'(bus1.res_iter), 3);
        chk("m3_c500_escaped", longint'(bus1.res_escaped), 0);
        ack(1);

        // x=7072 -> wx=50013, |z|^2 = 2501300169 wraps negative: overflow escape
        send(1, 7072, 0, 0, 0);
        wait_res(1, 100);
        chk("m3_ovf_iter", longint'(bus1.res_iter), 1);
        chk("m3_ovf_escaped", longint'(bus1.res_escaped), 1);
        ack(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
